// File: rtl/demux_1in_2out_buf.sv
// 1-to-2 demultiplexer with an independent 2-entry FIFO and a pop counter per output port.
// The Sel bit steers each accepted word into queue A (Sel=0) or queue B (Sel=1).
module demux_1in_2out_buf #(
    parameter int unsigned DB = 32,
    parameter int unsigned CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [DB-1:0] Dato,
    input  logic          Sel,
    input  logic          EntradaValid,
    output logic          EntradaReady,
    output logic [DB-1:0] SalidaA,
    output logic          ValidA,
    input  logic          ReadyA,
    output logic [DB-1:0] SalidaB,
    output logic          ValidB,
    input  logic          ReadyB,
    output logic [CW-1:0] CuentaA,
    output logic [CW-1:0] CuentaB
);

    // Per-port state, index 0 = port A, index 1 = port B.
    logic [1:0]    occ_q  [2];
    logic [1:0]    occ_d  [2];
    logic [DB-1:0] head_q [2];
    logic [DB-1:0] head_d [2];
    logic [DB-1:0] tail_q [2];
    logic [DB-1:0] tail_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];

    logic [1:0] dest;
    logic [1:0] full;
    logic [1:0] valid;
    logic [1:0] push;
    logic [1:0] pop;
    logic       accept;

    always_comb begin
        dest         = {Sel, ~Sel};
        full         = {occ_q[1] == 2'd2, occ_q[0] == 2'd2};
        valid        = {occ_q[1] != 2'd0, occ_q[0] != 2'd0};
        // Ready looks only at the selected queue's registered occupancy.
        EntradaReady = Sel ? ~full[1] : ~full[0];
        accept       = EntradaValid & EntradaReady;
        push         = dest & {2{accept}};
        pop          = valid & {ReadyB, ReadyA};
    end

    // Head register always holds the oldest word; tail holds the second one.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            occ_d[p]  = occ_q[p];
            head_d[p] = head_q[p];
            tail_d[p] = tail_q[p];
            cnt_d[p]  = cnt_q[p];

            case (occ_q[p])
                2'd0: begin
                    if (push[p]) begin
                        head_d[p] = Dato;
                        occ_d[p]  = 2'd1;
                    end
                end
                2'd1: begin
                    case ({push[p], pop[p]})
                        2'b11: head_d[p] = Dato;
                        2'b10: begin
                            tail_d[p] = Dato;
                            occ_d[p]  = 2'd2;
                        end
                        2'b01: occ_d[p] = 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // Push cannot occur here: ready is low while full.
                    if (pop[p]) begin
                        head_d[p] = tail_q[p];
                        occ_d[p]  = 2'd1;
                    end
                end
                default: occ_d[p] = 2'd0;
            endcase

            if (pop[p]) begin
                cnt_d[p] = cnt_q[p] + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int p = 0; p < 2; p++) begin
                occ_q[p]  <= 2'd0;
                head_q[p] <= '0;
                tail_q[p] <= '0;
                cnt_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                occ_q[p]  <= occ_d[p];
                head_q[p] <= head_d[p];
                tail_q[p] <= tail_d[p];
                cnt_q[p]  <= cnt_d[p];
            end
        end
    end

    always_comb begin
        SalidaA = head_q[0];
        SalidaB = head_q[1];
        ValidA  = valid[0];
        ValidB  = valid[1];
        CuentaA = cnt_q[0];
        CuentaB = cnt_q[1];
    end

`ifndef SYNTHESIS
    occ_legal_a : assert property (@(posedge Clk) disable iff (Reset) occ_q[0] != 2'd3);
    occ_legal_b : assert property (@(posedge Clk) disable iff (Reset) occ_q[1] != 2'd3);
    stall_stable_a : assert property (@(posedge Clk) disable iff (Reset)
        ValidA && !ReadyA |=> Reset || $stable(SalidaA));
    stall_stable_b : assert property (@(posedge Clk) disable iff (Reset)
        ValidB && !ReadyB |=> Reset || $stable(SalidaB));
`endif

endmodule

// File: tb/tb_demux_1in_2out_buf.sv
// Randomized and directed bench for demux_1in_2out_buf against a queue-based reference model.
module tb_demux_1in_2out_buf;

    localparam int DB = 32;
    localparam int CW = 4;

    logic          Clk;
    logic          Reset;
    logic [DB-1:0] Dato;
    logic          Sel;
    logic          EntradaValid;
    logic          EntradaReady;
    logic [DB-1:0] SalidaA;
    logic          ValidA;
    logic          ReadyA;
    logic [DB-1:0] SalidaB;
    logic          ValidB;
    logic          ReadyB;
    logic [CW-1:0] CuentaA;
    logic [CW-1:0] CuentaB;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one queue per port plus pop counts.
    logic [DB-1:0] qa[$];
    logic [DB-1:0] qb[$];
    int            cnt_a = 0;
    int            cnt_b = 0;
    bit            after_rst = 1'b0;

    demux_1in_2out_buf #(
        .DB(DB),
        .CW(CW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Dato        (Dato),
        .Sel         (Sel),
        .EntradaValid(EntradaValid),
        .EntradaReady(EntradaReady),
        .SalidaA     (SalidaA),
        .ValidA      (ValidA),
        .ReadyA      (ReadyA),
        .SalidaB     (SalidaB),
        .ValidB      (ValidB),
        .ReadyB      (ReadyB),
        .CuentaA     (CuentaA),
        .CuentaB     (CuentaB)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic cycle(input logic rst, input logic v, input logic s,
                         input logic [DB-1:0] d, input logic ra, input logic rb);
        bit acc;
        bit pa;
        bit pb;
        Reset        = rst;
        EntradaValid = v;
        Sel          = s;
        Dato         = d;
        ReadyA       = ra;
        ReadyB       = rb;
        #1;
        check("validA", ValidA, qa.size() > 0);
        check("validB", ValidB, qb.size() > 0);
        if (qa.size() > 0) check("salidaA", SalidaA, qa[0]);
        if (qb.size() > 0) check("salidaB", SalidaB, qb[0]);
        check("ready", EntradaReady, s ? (qb.size() < 2) : (qa.size() < 2));
        check("cuentaA", CuentaA, cnt_a);
        check("cuentaB", CuentaB, cnt_b);
        if (after_rst) begin
            check("rst_salidaA", SalidaA, 0);
            check("rst_salidaB", SalidaB, 0);
        end
        acc = v && (s ? (qb.size() < 2) : (qa.size() < 2));
        pa  = ra && (qa.size() > 0);
        pb  = rb && (qb.size() > 0);
        @(posedge Clk);
        after_rst = rst;
        if (rst) begin
            qa.delete();
            qb.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (pa) begin
                void'(qa.pop_front());
                cnt_a = (cnt_a + 1) % (1 << CW);
            end
            if (pb) begin
                void'(qb.pop_front());
                cnt_b = (cnt_b + 1) % (1 << CW);
            end
            if (acc) begin
                if (s) qb.push_back(d);
                else   qa.push_back(d);
            end
        end
        @(negedge Clk);
    endtask

    initial begin
        Reset        = 1'b1;
        Dato         = '0;
        Sel          = 1'b0;
        EntradaValid = 1'b0;
        ReadyA       = 1'b0;
        ReadyB       = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset     = 1'b0;
        after_rst = 1'b1;
        Sel       = 1'b0;
        #1 check("init_rdy_sel0", EntradaReady, 1);
        Sel = 1'b1;
        #1 check("init_rdy_sel1", EntradaReady, 1);

        // Single word through port A.
        cycle(0, 1, 0, 32'hA5A5A5A5, 1, 0);
        cycle(0, 0, 0, 32'h0, 1, 0);
        cycle(0, 0, 0, 32'h0, 1, 0);
        check("d_cntA_one", CuentaA, 1);

        // Fill B while stalled; A still accepts.
        cycle(0, 1, 1, 32'd1, 0, 0);
        cycle(0, 1, 1, 32'd2, 0, 0);
        cycle(0, 1, 1, 32'd9, 0, 0);
        cycle(0, 1, 0, 32'd3, 0, 0);
        repeat (3) cycle(0, 0, 0, 32'h0, 1, 1);

        // Full A: push refused while popping.
        cycle(0, 1, 0, 32'h11, 0, 0);
        cycle(0, 1, 0, 32'h22, 0, 0);
        cycle(0, 1, 0, 32'h33, 1, 0);
        // Occupancy 1: simultaneous push and pop.
        cycle(0, 1, 0, 32'h7, 1, 0);
        cycle(0, 0, 0, 32'h0, 0, 0);
        check("d_headA_7", SalidaA, 32'h7);
        cycle(0, 0, 0, 32'h0, 1, 0);

        // Counter wrap on port B: 16 pops.
        cycle(1, 0, 0, 32'h0, 0, 0);
        for (int k = 0; k <= 16; k++) cycle(0, 1, 1, DB'(k + 100), 0, 1);
        #1 check("d_cntB_wrap", CuentaB, 0);

        // Reset with both queues full overrides push and pop.
        cycle(0, 1, 0, 32'hAA, 0, 0);
        cycle(0, 1, 0, 32'hAB, 0, 0);
        cycle(0, 1, 1, 32'hBA, 0, 0);
        cycle(0, 1, 1, 32'hBB, 0, 0);
        cycle(1, 1, 0, 32'hFF, 1, 1);
        Reset = 1'b0;
        Sel   = 1'b1;
        #1;
        check("r_rdy_sel1", EntradaReady, 1);
        check("r_validA", ValidA, 0);
        check("r_validB", ValidB, 0);
        check("r_salidaA", SalidaA, 0);
        check("r_salidaB", SalidaB, 0);
        check("r_cntA", CuentaA, 0);
        check("r_cntB", CuentaB, 0);
        cycle(0, 0, 0, 32'h0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(63) == 0, $urandom_range(9) < 7, 1'($urandom_range(1)),
                  DB'($urandom), $urandom_range(3) != 0, $urandom_range(2) != 0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
